// File: rtl/fifo_uart_drain.sv
// Read-side FIFO consumer: pops one word per frame and sends it as a UART frame
// (start bit, LSB-first data, optional parity, stop bit) with no gap between back-to-back frames.
module fifo_uart_drain #(
  parameter int width    = 8,
  parameter int PRESCALE = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TX_EN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             EMPTY,
  input  logic [width-1:0] RD_DATA,
  output logic             R_INC,
  output logic             TX_OUT,
  output logic             BUSY
);

  localparam int IDX_W = (width > 1) ? $clog2(width) : 1;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [width-1:0] shift_reg;
  logic             par_en_q;
  logic             par_bit;

  logic             bit_last;
  logic             pop;
  logic [width-1:0] shift_nxt;

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    bit_last  = 1'b0;
    pop       = 1'b0;
    shift_nxt = shift_reg >> 1;
    bit_last  = (bit_cnt == CNT_W'(PRESCALE - 1));
    // Reset masks the pop so the FIFO never loses a word while RST is held.
    pop       = !RST && TX_EN && !EMPTY &&
                ((state == IDLE) || ((state == STOP) && bit_last));
  end

  assign R_INC = pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit   <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      // The bit counter wraps at each bit boundary, which is also every state change.
      if (state == IDLE || bit_last) bit_cnt <= '0;
      else                           bit_cnt <= bit_cnt + CNT_W'(1);

      unique case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
          if (pop) begin
            shift_reg <= RD_DATA;
            par_en_q  <= PAR_EN;
            par_bit   <= (^RD_DATA) ^ PAR_TYP;
            state     <= START;
            TX_OUT    <= 1'b0;
            BUSY      <= 1'b1;
          end
        end

        START: begin
          if (bit_last) begin
            state   <= DATA;
            bit_idx <= '0;
            TX_OUT  <= shift_reg[0];
          end
        end

        DATA: begin
          if (bit_last) begin
            if (bit_idx == IDX_W'(width - 1)) begin
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              shift_reg <= shift_nxt;
              TX_OUT    <= shift_nxt[0];
            end
          end
        end

        PARITY: begin
          if (bit_last) begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
        end

        STOP: begin
          if (bit_last) begin
            if (pop) begin
              shift_reg <= RD_DATA;
              par_en_q  <= PAR_EN;
              par_bit   <= (^RD_DATA) ^ PAR_TYP;
              state     <= START;
              TX_OUT    <= 1'b0;
            end else begin
              state  <= IDLE;
              TX_OUT <= 1'b1;
              BUSY   <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain: a FIFO model feeds words, and a scoreboard
// turns each popped word into the expected per-cycle line waveform.
module tb_fifo_uart_drain;

  localparam int W     = 8;
  localparam int PRESC = 4;

  logic         CLK;
  logic         RST;
  logic         TX_EN;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         EMPTY;
  logic [W-1:0] RD_DATA;
  logic         R_INC;
  logic         TX_OUT;
  logic         BUSY;

  fifo_uart_drain #(.width(W), .PRESCALE(PRESC)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .TX_EN   (TX_EN),
    .PAR_EN  (PAR_EN),
    .PAR_TYP (PAR_TYP),
    .EMPTY   (EMPTY),
    .RD_DATA (RD_DATA),
    .R_INC   (R_INC),
    .TX_OUT  (TX_OUT),
    .BUSY    (BUSY)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         par_en;
    logic         par_typ;
  } sb_t;

  logic [W-1:0] fifo_q [$];
  sb_t          sb_q   [$];
  logic         exp_line [$];
  int           pop_cycles [$];
  logic         line_log [0:2047];
  logic [W-1:0] junk_data;

  int n_checks;
  int n_fail;
  int cyc;
  int rinc_cnt;
  int busy_cnt;
  logic rinc_seen;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    EMPTY   = (fifo_q.size() == 0);
    RD_DATA = (fifo_q.size() == 0) ? junk_data : fifo_q[0];
  endtask

  task automatic push(input logic [W-1:0] d);
    sb_t e;
    e.data    = d;
    e.par_en  = PAR_EN;
    e.par_typ = PAR_TYP;
    fifo_q.push_back(d);
    sb_q.push_back(e);
    drive_fifo();
  endtask

  task automatic push_bit(input logic v);
    for (int b = 0; b < PRESC; b++) exp_line.push_back(v);
  endtask

  // Per-cycle monitor, called at the falling edge.
  task automatic sample();
    logic exp_tx;
    logic exp_busy;
    logic exp_rinc;
    sb_t  e;
    cyc++;
    line_log[cyc % 2048] = TX_OUT;
    if (RST) begin
      exp_line.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_rinc = 1'b0;
    end else begin
      if (exp_line.size() != 0) begin
        exp_tx   = exp_line.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
      exp_rinc = TX_EN && !EMPTY && (exp_line.size() == 0);
    end
    check("tx_out", {31'd0, TX_OUT}, {31'd0, exp_tx});
    check("busy",   {31'd0, BUSY},   {31'd0, exp_busy});
    check("r_inc",  {31'd0, R_INC},  {31'd0, exp_rinc});
    if (BUSY === 1'b1) busy_cnt++;
    rinc_seen = (R_INC === 1'b1);
    if (rinc_seen) begin
      rinc_cnt++;
      pop_cycles.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("pop_without_data", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        push_bit(1'b0);
        for (int i = 0; i < W; i++) push_bit(e.data[i]);
        if (e.par_en) push_bit((^e.data) ^ e.par_typ);
        push_bit(1'b1);
      end
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    sample();
    @(posedge CLK);
    #1;
    if (rinc_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    rinc_cnt = 0;
    busy_cnt = 0;
    pop_cycles.delete();
  endtask

  // Line value in the middle of frame bit k (0 = start bit) of the frame popped at cycle p.
  function automatic logic line_bit(input int p, input int k);
    return line_log[(p + 1 + PRESC * k + PRESC / 2) % 2048];
  endfunction

  initial begin
    logic [9:0] pat_a5;
    int p;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    junk_data = '0;
    rinc_seen = 1'b0;
    clear_counts();
    RST     = 1'b1;
    TX_EN   = 1'b0;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    drive_fifo();
    #2;
    check("reset_tx_out", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy",   {31'd0, BUSY},   32'd0);
    check("reset_r_inc",  {31'd0, R_INC},  32'd0);
    run(3);
    RST = 1'b0;
    run(2);

    // Single byte, no parity.
    TX_EN = 1'b1;
    clear_counts();
    push(8'hA5);
    run(50);
    check("a5_pops", rinc_cnt, 32'd1);
    check("a5_busy_cycles", busy_cnt, 32'd40);
    pat_a5 = 10'b1101001010;
    p = (pop_cycles.size() != 0) ? pop_cycles[0] : 0;
    for (int k = 0; k < 10; k++)
      check($sformatf("a5_line_bit%0d", k), {31'd0, line_bit(p, k)}, {31'd0, pat_a5[k]});

    // Parity variants.
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    clear_counts();
    push(8'hA5);
    run(50);
    p = (pop_cycles.size() != 0) ? pop_cycles[0] : 0;
    check("a5_even_busy_cycles", busy_cnt, 32'd44);
    check("a5_even_parity", {31'd0, line_bit(p, 9)}, 32'd0);
    check("a5_even_stop", {31'd0, line_bit(p, 10)}, 32'd1);

    PAR_TYP = 1'b1;
    clear_counts();
    push(8'hA5);
    run(50);
    p = (pop_cycles.size() != 0) ? pop_cycles[0] : 0;
    check("a5_odd_parity", {31'd0, line_bit(p, 9)}, 32'd1);

    PAR_TYP = 1'b0;
    clear_counts();
    push(8'h07);
    run(50);
    p = (pop_cycles.size() != 0) ? pop_cycles[0] : 0;
    check("07_even_parity", {31'd0, line_bit(p, 9)}, 32'd1);

    // Back-to-back frames.
    PAR_EN = 1'b0;
    clear_counts();
    push(8'h01);
    push(8'hFF);
    push(8'h3C);
    run(130);
    check("b2b_pops", rinc_cnt, 32'd3);
    check("b2b_busy_cycles", busy_cnt, 32'd120);
    if (pop_cycles.size() == 3) begin
      check("b2b_spacing_1", pop_cycles[1] - pop_cycles[0], 32'd40);
      check("b2b_spacing_2", pop_cycles[2] - pop_cycles[1], 32'd40);
    end else begin
      check("b2b_pop_count", pop_cycles.size(), 32'd3);
    end
    check("b2b_idle_busy", {31'd0, BUSY}, 32'd0);

    // Enable gating.
    TX_EN = 1'b0;
    clear_counts();
    push(8'h55);
    run(20);
    check("gated_pops", rinc_cnt, 32'd0);
    TX_EN = 1'b1;
    clear_counts();
    cycle();
    push(8'h66);
    run(10);
    TX_EN = 1'b0;
    run(40);
    check("tx_en_drop_pops", rinc_cnt, 32'd1);
    check("tx_en_drop_busy", busy_cnt, 32'd40);

    // Reset during data bit 3.
    TX_EN = 1'b1;
    clear_counts();
    cycle();
    push(8'h77);
    run(17);
    RST = 1'b1;
    #1;
    check("midreset_tx_out", {31'd0, TX_OUT}, 32'd1);
    check("midreset_busy",   {31'd0, BUSY},   32'd0);
    check("midreset_r_inc",  {31'd0, R_INC},  32'd0);
    run(2);
    RST = 1'b0;
    clear_counts();
    run(50);
    check("post_reset_pops", rinc_cnt, 32'd1);
    check("post_reset_busy", busy_cnt, 32'd40);

    // Inputs changed after the pop must not affect the frame.
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    clear_counts();
    push(8'hA5);
    cycle();
    PAR_EN = 1'b0;
    PAR_TYP = 1'b1;
    junk_data = 8'h5A;
    drive_fifo();
    run(50);
    p = (pop_cycles.size() != 0) ? pop_cycles[0] : 0;
    check("sampled_busy_cycles", busy_cnt, 32'd44);
    check("sampled_parity", {31'd0, line_bit(p, 9)}, 32'd0);
    for (int k = 1; k < 9; k++)
      check($sformatf("sampled_data_bit%0d", k - 1), {31'd0, line_bit(p, k)}, {31'd0, pat_a5[k]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Read-side consumer for the dual-clock FIFO. It runs in the FIFO read clock domain. Whenever the FIFO is not empty and transmission is enabled, it pops one word and serializes it as a UART frame: a start bit, the data LSB first, optional parity, then a stop bit. It drives the FIFO read-increment strobe directly and sustains back-to-back frames with no idle gap while data remains.

## Interface
Parameters:
- width, 8, data word width; must match the FIFO data width.
- PRESCALE, 16, CLK cycles per serial bit; legal range 2..255.

Ports:
- CLK  input  1  read-domain clock; the same clock that drives the FIFO read side.
- RST  input  1  asynchronous, active-high reset.
- TX_EN  input  1  when high, the block may start a new frame; sampled only in IDLE and in the last cycle of STOP.
- PAR_EN  input  1  when 1, the frame includes a parity bit; sampled in the pop cycle.
- PAR_TYP  input  1  parity type, 0 = even, 1 = odd; sampled in the pop cycle.
- EMPTY  input  1  FIFO empty flag, already synchronized to CLK.
- RD_DATA  input  width  FIFO head word; combinationally valid whenever EMPTY=0.
- R_INC  output  1  single-cycle pop strobe to the FIFO.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  high from the cycle after a pop until the end of that frame's stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition: state is IDLE, or state is STOP in its final cycle, AND EMPTY=0 AND TX_EN=1.
  - R_INC is combinational and equals the pop condition.
  - In the same cycle the block registers RD_DATA into the shift register, and latches PAR_EN and PAR_TYP.
  - The parity bit is computed from the captured word as XOR-reduce(word) XOR PAR_TYP.
  - Next state is START.
- A bit counter (0..PRESCALE-1) holds each serial bit for exactly PRESCALE cycles. The counter clears on every state change.
- START: TX_OUT=0 for PRESCALE cycles, then go to DATA.
- DATA: transmit width bits LSB first, tracked by an index of clog2(width) bits. After bit width-1, go to PARITY if the latched PAR_EN=1, otherwise go to STOP.
- PARITY: TX_OUT = the computed parity bit for PRESCALE cycles, then go to STOP.
- STOP: TX_OUT=1 for PRESCALE cycles. In the last cycle, go to START if the pop condition holds, otherwise go to IDLE.
- IDLE: TX_OUT=1 and BUSY=0.
- R_INC is never asserted when EMPTY=1, and never more than once per frame.
- TX_EN falling mid-frame: the current frame completes normally; no further pop occurs.
- PAR_EN, PAR_TYP or RD_DATA changing mid-frame has no effect on the frame in flight.

## Timing
- Reset values (asynchronous): state=IDLE, TX_OUT=1, BUSY=0, counters=0, shift register=0. R_INC=0 because the state is IDLE and reset forces the pop condition false.
- Reset mid-frame: TX_OUT returns to 1 immediately. The popped word is discarded and no pop is issued while RST=1.
- Pop-to-line latency: start bit appears on TX_OUT one cycle after the R_INC cycle. TX_OUT is registered.
- Frame length: PRESCALE × (width + 2 + PAR_EN) cycles.
- Back-to-back frames: the next start bit immediately follows the last stop-bit cycle, with zero idle cycles.
- EMPTY deasserting in IDLE: the pop occurs in that same cycle, provided TX_EN=1.

## Test plan
- Single byte, no parity: PRESCALE=4, RD_DATA=0xA5, PAR_EN=0, EMPTY falls for one word.
  - R_INC pulses once.
  - TX_OUT reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - BUSY is high for exactly 40 cycles.
- Parity: 0xA5 with PAR_EN=1, PAR_TYP=0 gives parity bit 0 and a 44-cycle frame. With PAR_TYP=1 the parity bit is 1. 0x07 with even parity gives parity bit 1.
- Back-to-back: FIFO holds 0x01, 0xFF, 0x3C.
  - Three R_INC pulses, each spaced exactly one frame apart.
  - No idle-high gap between frames.
  - EMPTY=1 afterwards leaves the block in IDLE with BUSY=0.
- Enable gating: with TX_EN=0 and EMPTY=0, no R_INC and TX_OUT stays 1. Dropping TX_EN mid-frame lets that frame finish, with no second pop.
- Reset mid-frame: assert RST during DATA bit 3.
  - TX_OUT=1 and BUSY=0 immediately.
  - After release with EMPTY=0, the next frame starts with a fresh pop.
- Sampling: changing RD_DATA, PAR_EN and PAR_TYP one cycle after the pop leaves the serialized frame unchanged.
